// File: rtl/mio_pkg.sv
// Shared constants and types for the memory/IO responder: address map and FSM states.
package mio_pkg;

    localparam logic [31:0] MIO_RAM_BASE = 32'h0000_0000;
    localparam logic [31:0] MIO_LED_ADDR = 32'hF000_0000;
    localparam logic [31:0] MIO_SW_ADDR  = 32'hF000_0004;
    localparam logic [31:0] MIO_CNT_ADDR = 32'hF000_0008;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } mio_state_t;

    // Word-granular compare; byte offset bits are ignored by the bus.
    function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

endpackage

// File: rtl/mio_ram.sv
// Single-port synchronous word RAM, read-before-write.
module mio_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   din,
    output logic [31:0]   dout
);

    logic [31:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= din;
        dout <= mem[addr];
    end

endmodule

// File: rtl/mio_bus_responder.sv
// Memory/IO responder: decodes CPU accesses to a word RAM or peripheral registers
// and completes them with a MIO_ready wait-state handshake.
module mio_bus_responder
    import mio_pkg::*;
#(
    parameter int RAM_AW   = 10,
    parameter int RAM_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [31:0] M_addr,
    input  logic [31:0] data_out,
    input  logic [15:0] sw,
    output logic [31:0] data2CPU,
    output logic        MIO_ready,
    output logic [15:0] led,
    output logic        addr_err
);

    mio_state_t  state;
    logic [2:0]  wait_cnt;
    logic [31:0] cnt;
    logic [31:0] ram_dout;
    logic [31:0] rd_data;
    logic        req;
    logic        is_ram, is_led, is_sw, is_cnt, is_unmapped;
    logic        commit, wr, rd;
    logic        unused_addr_lsbs;

    assign unused_addr_lsbs = ^M_addr[1:0];

    assign req    = mem_r | mem_w;
    assign commit = (state == DONE) && req;
    assign wr     = commit && mem_w;
    assign rd     = commit && !mem_w;

    assign is_ram      = (M_addr[31:RAM_AW+2] == MIO_RAM_BASE[31:RAM_AW+2]);
    assign is_led      = word_match(M_addr, MIO_LED_ADDR);
    assign is_sw       = word_match(M_addr, MIO_SW_ADDR);
    assign is_cnt      = word_match(M_addr, MIO_CNT_ADDR);
    assign is_unmapped = !(is_ram || is_led || is_sw || is_cnt);

    assign MIO_ready = ((state == IDLE) && !req) || (state == DONE);

    // Write enable is gated by reset so an access interrupted in DONE never lands.
    mio_ram #(.AW(RAM_AW)) u_ram (
        .clk  (clk),
        .we   (wr && is_ram && !reset),
        .addr (M_addr[RAM_AW+1:2]),
        .din  (data_out),
        .dout (ram_dout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            addr_err <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (is_ram && (RAM_WAIT != 0)) begin
                            state    <= WAIT;
                            wait_cnt <= 3'(RAM_WAIT);
                        end else begin
                            state    <= DONE;
                            addr_err <= is_unmapped;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state <= IDLE;
                    end else if (wait_cnt <= 3'd1) begin
                        state    <= DONE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        if (is_ram)
            rd_data = ram_dout;
        else if (is_led)
            rd_data = {16'h0000, led};
        else if (is_sw)
            rd_data = {16'h0000, sw};
        else if (is_cnt)
            rd_data = cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data2CPU <= '0;
            led      <= '0;
            cnt      <= '0;
        end else begin
            cnt <= (wr && is_cnt) ? data_out : cnt + 32'd1;
            if (wr && is_led)
                led <= data_out[15:0];
            if (rd)
                data2CPU <= rd_data;
        end
    end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Self-checking bench for mio_bus_responder: directed scenarios plus random traffic
// compared against an address-map level reference model.
module tb_mio_bus_responder;

    localparam int AW    = 6;
    localparam int WAITS = 2;
    localparam int WORDS = 2 ** AW;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_r, mem_w;
    logic [31:0] M_addr, data_out;
    logic [15:0] sw;
    logic [31:0] data2CPU;
    logic        MIO_ready;
    logic [15:0] led;
    logic        addr_err;

    mio_bus_responder #(.RAM_AW(AW), .RAM_WAIT(WAITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_r     (mem_r),
        .mem_w     (mem_w),
        .M_addr    (M_addr),
        .data_out  (data_out),
        .sw        (sw),
        .data2CPU  (data2CPU),
        .MIO_ready (MIO_ready),
        .led       (led),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] ram_m [WORDS];
    logic [15:0] exp_led;
    logic [31:0] exp_d2c;
    logic [31:0] cnt_load;
    int          cnt_edge;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // 0 ram, 1 led, 2 switches, 3 counter, 4 unmapped
    function automatic int kind(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w < 32'(4 * WORDS)) return 0;
        if (w == 32'hF000_0000) return 1;
        if (w == 32'hF000_0004) return 2;
        if (w == 32'hF000_0008) return 3;
        return 4;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[AW+1:2]);
    endfunction

    task automatic model_reset();
        exp_d2c  = '0;
        exp_led  = '0;
        cnt_load = '0;
        cnt_edge = cyc;
    endtask

    task automatic xact(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
        int   lat, k, c;
        logic err;
        k = kind(a);
        @(negedge clk);
        mem_r = r; mem_w = w; M_addr = a; data_out = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (MIO_ready !== 1'b1 && lat < 20);
        err = addr_err;
        c   = cyc;
        @(posedge clk);
        #1;
        mem_r = 1'b0; mem_w = 1'b0;
        if (w) begin
            if (k == 0) ram_m[widx(a)] = d;
            if (k == 1) exp_led = d[15:0];
            if (k == 3) begin cnt_load = d; cnt_edge = c + 1; end
        end else if (r) begin
            case (k)
                0:       exp_d2c = ram_m[widx(a)];
                1:       exp_d2c = {16'h0000, exp_led};
                2:       exp_d2c = {16'h0000, sw};
                3:       exp_d2c = cnt_load + 32'(c - cnt_edge);
                default: exp_d2c = '0;
            endcase
        end
        @(negedge clk);
        check({tag, "_latency"}, 32'(lat), (k == 0) ? 32'(1 + WAITS) : 32'd1);
        check({tag, "_addr_err"}, {31'b0, err}, {31'b0, k == 4});
        check({tag, "_addr_err_pulse"}, {31'b0, addr_err}, 32'd0);
        check({tag, "_ready_idle"}, {31'b0, MIO_ready}, 32'd1);
        check({tag, "_data2CPU"}, data2CPU, exp_d2c);
        check({tag, "_led"}, {16'h0000, led}, {16'h0000, exp_led});
    endtask

    // Assert reset while a RAM write is held `hold` cycles into the access.
    task automatic reset_mid(input logic [31:0] a, input logic [31:0] d, input int hold, input string tag);
        @(negedge clk);
        mem_w = 1'b1; M_addr = a; data_out = d;
        repeat (hold) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; mem_w = 1'b0;
        @(negedge clk);
        model_reset();
        check({tag, "_ready"}, {31'b0, MIO_ready}, 32'd1);
        check({tag, "_data2CPU"}, data2CPU, 32'd0);
        check({tag, "_led"}, {16'h0000, led}, 32'd0);
    endtask

    initial begin
        logic [31:0] a, d;
        logic        r, w;
        int          sel;

        reset = 1'b1; mem_r = 1'b0; mem_w = 1'b0;
        M_addr = '0; data_out = '0; sw = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("reset_ready", {31'b0, MIO_ready}, 32'd1);
        check("reset_data2CPU", data2CPU, 32'd0);
        check("reset_led", {16'h0000, led}, 32'd0);
        check("reset_addr_err", {31'b0, addr_err}, 32'd0);

        for (int i = 0; i < WORDS; i++)
            xact(1'b0, 1'b1, 32'(4 * i), $urandom, "fill");

        xact(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "ram_wr");
        xact(1'b1, 1'b0, 32'h0000_0010, 32'h0, "ram_rd");
        xact(1'b0, 1'b1, 32'hF000_0000, 32'h1234_A5A5, "led_wr");
        xact(1'b1, 1'b0, 32'hF000_0000, 32'h0, "led_rd");
        sw = 16'h00FF;
        xact(1'b1, 1'b0, 32'hF000_0004, 32'h0, "sw_rd");
        xact(1'b0, 1'b1, 32'hF000_0004, 32'hFFFF_FFFF, "sw_wr_ignored");
        xact(1'b0, 1'b1, 32'hF000_0008, 32'hFFFF_FFFE, "cnt_wr");
        repeat (3) @(negedge clk);
        xact(1'b1, 1'b0, 32'hF000_0008, 32'h0, "cnt_wrap_rd");
        xact(1'b1, 1'b0, 32'h8000_0000, 32'h0, "unmapped_rd");
        xact(1'b1, 1'b0, 32'(4 * WORDS), 32'h0, "ram_edge_unmapped");
        xact(1'b1, 1'b0, 32'(4 * WORDS - 1), 32'h0, "ram_last_word");
        xact(1'b1, 1'b1, 32'hF000_0000, 32'h5A5A_1111, "both_strobes_led");

        // Abort a RAM write in WAIT; the location must keep its old value.
        @(negedge clk);
        mem_w = 1'b1; M_addr = 32'h0000_0020; data_out = 32'hBAD0_BAD0;
        @(negedge clk);
        mem_w = 1'b0;
        @(negedge clk);
        check("abort_ready", {31'b0, MIO_ready}, 32'd1);
        check("abort_data2CPU", data2CPU, exp_d2c);
        xact(1'b1, 1'b0, 32'h0000_0020, 32'h0, "abort_readback");

        reset_mid(32'h0000_0030, 32'h0BAD_F00D, 1, "rst_wait");
        xact(1'b1, 1'b0, 32'h0000_0030, 32'h0, "rst_wait_readback");
        reset_mid(32'h0000_0034, 32'hF00D_0BAD, 1 + WAITS, "rst_done");
        xact(1'b1, 1'b0, 32'h0000_0034, 32'h0, "rst_done_readback");
        xact(1'b1, 1'b0, 32'hF000_0008, 32'h0, "cnt_after_reset");

        for (int i = 0; i < 150; i++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2, 3: a = {$urandom_range(0, WORDS - 1), 2'b00} | 32'($urandom_range(0, 3));
                4:          a = 32'hF000_0000 | 32'($urandom_range(0, 3));
                5:          a = 32'hF000_0004;
                6:          a = 32'hF000_0008;
                7:          a = 32'hF000_000C;
                8:          a = 32'(4 * WORDS) + 32'(4 * $urandom_range(0, 15));
                default:    a = {1'b1, 31'($urandom)};
            endcase
            d   = $urandom;
            sel = int'($urandom_range(0, 4));
            r   = (sel != 0);
            w   = (sel == 0) || (sel >= 3);
            sw  = 16'($urandom);
            xact(r, w, a, d, "rand");
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
